// File: rtl/sky_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sky_pkg
// Description : Shared state encoding and play-field geometry for the
//               falling-block game blocks (catch_judge, stack, draw).
// Revision    : 1.0 - initial release
// ============================================================================
package sky_pkg;

    // Judge FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_JUDGE    = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_OVER     = 3'd4
    } state_t;

    // Geometry defaults, in pixels
    localparam int BLOCK_W   = 40;
    localparam int BLOCK_H   = 20;
    localparam int STACK_W   = 80;
    localparam int FLOOR_Y   = 460;

    // Largest value the four-digit score display can show
    localparam int SCORE_MAX = 9999;

endpackage : sky_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up/down counter that saturates at 0 and MAX, with a
//               synchronous clear that loads CLR_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH   = 14,
    parameter int MAX     = 9999,
    parameter int CLR_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active low
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_CLR = WIDTH'(CLR_VAL);

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment, increment over decrement; both ends stick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= c_CLR;
        end else if (i_inc) begin
            if (r_count != c_MAX) r_count <= r_count + 1'b1;
        end else if (i_dec) begin
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/catch_judge.sv
`default_nettype none
// ============================================================================
// Module      : catch_judge
// Description : Decides catch/miss of the falling item against the stack top,
//               emits one-cycle catch/miss/respawn pulses and keeps score,
//               lives and game-over state.
// Revision    : 1.0 - initial release
// ============================================================================
module catch_judge
    import sky_pkg::*;
#(
    parameter int BLOCK_W    = sky_pkg::BLOCK_W,
    parameter int BLOCK_H    = sky_pkg::BLOCK_H,
    parameter int STACK_W    = sky_pkg::STACK_W,
    parameter int FLOOR_Y    = sky_pkg::FLOOR_Y,
    parameter int MAX_HEIGHT = 20,
    parameter int LIVES      = 3
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active low
    input  logic        fall_tick,
    input  logic        start,
    input  logic        pause,
    input  logic [9:0]  fall_x,
    input  logic [9:0]  fall_y,
    input  logic [1:0]  fall_clr,
    input  logic [9:0]  stack_x,
    input  logic [9:0]  height,
    output logic        catch_pulse,
    output logic [1:0]  push_clr,
    output logic        miss_pulse,
    output logic        respawn,
    output logic [13:0] score,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        win
);

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_cap_x;
    logic [1:0]  r_cap_clr;
    logic        r_catch, r_miss, r_respawn, r_game_over, r_win;
    logic [1:0]  r_push_clr;

    logic        w_catch, w_miss, w_respawn, w_game_over, w_win;
    logic [1:0]  w_push_clr;
    logic        w_capture, w_clr_cnt, w_score_inc, w_lives_dec;

    // Landing line: floor minus the stack height, clamped at the top edge
    logic [15:0] w_hmul;
    logic [10:0] w_land, w_bottom, w_item_r, w_stack_r;
    logic        w_landed, w_hit, w_top, w_tick;

    assign w_hmul    = 16'(height) * 16'(BLOCK_H);
    assign w_land    = (w_hmul >= 16'(FLOOR_Y)) ? 11'd0 : 11'(16'(FLOOR_Y) - w_hmul);
    assign w_bottom  = 11'(fall_y) + 11'(BLOCK_H);
    assign w_landed  = (w_bottom >= w_land);
    assign w_tick    = fall_tick && !pause;
    // Strict inequalities: touching edges do not count as overlap
    assign w_item_r  = 11'(r_cap_x) + 11'(BLOCK_W);
    assign w_stack_r = 11'(stack_x) + 11'(STACK_W);
    assign w_hit     = (w_item_r > 11'(stack_x)) && (11'(r_cap_x) < w_stack_r);
    assign w_top     = (11'(height) + 11'd1) >= 11'(MAX_HEIGHT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state and next registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_catch     = 1'b0;
        w_miss      = 1'b0;
        w_respawn   = 1'b0;
        w_push_clr  = 2'd0;
        w_game_over = r_game_over;
        w_win       = r_win;
        w_capture   = 1'b0;
        w_clr_cnt   = 1'b0;
        w_score_inc = 1'b0;
        w_lives_dec = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                // Start takes precedence over any coincident tick
                if (start) begin
                    w_state_nxt = ST_PLAY;
                    w_clr_cnt   = 1'b1;
                    w_game_over = 1'b0;
                    w_win       = 1'b0;
                end
            end
            ST_PLAY: begin
                if (w_tick && w_landed) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                w_respawn = 1'b1;
                if (w_hit) begin
                    w_catch     = 1'b1;
                    w_push_clr  = r_cap_clr;
                    w_score_inc = 1'b1;
                    if (w_top) begin
                        w_state_nxt = ST_OVER;
                        w_game_over = 1'b1;
                        w_win       = 1'b1;
                    end else begin
                        w_state_nxt = ST_COOLDOWN;
                    end
                end else begin
                    w_miss      = 1'b1;
                    w_lives_dec = 1'b1;
                    if (lives <= 2'd1) begin
                        w_state_nxt = ST_OVER;
                        w_game_over = 1'b1;
                        w_win       = 1'b0;
                    end else begin
                        w_state_nxt = ST_COOLDOWN;
                    end
                end
            end
            ST_COOLDOWN: begin
                // Wait until the respawned item is above the landing line
                if (w_tick && !w_landed) w_state_nxt = ST_PLAY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered pulses, colour and game status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_catch     <= 1'b0;
            r_miss      <= 1'b0;
            r_respawn   <= 1'b0;
            r_push_clr  <= 2'd0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            r_catch     <= w_catch;
            r_miss      <= w_miss;
            r_respawn   <= w_respawn;
            r_push_clr  <= w_push_clr;
            r_game_over <= w_game_over;
            r_win       <= w_win;
        end
    end

    // Item position and colour frozen at the landing tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_x   <= 10'd0;
            r_cap_clr <= 2'd0;
        end else if (w_capture) begin
            r_cap_x   <= fall_x;
            r_cap_clr <= fall_clr;
        end
    end

    sat_counter #(.WIDTH(14), .MAX(SCORE_MAX), .CLR_VAL(0)) u_score (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr_cnt),
        .i_inc   (w_score_inc),
        .i_dec   (1'b0),
        .o_count (score)
    );

    sat_counter #(.WIDTH(2), .MAX(LIVES), .CLR_VAL(LIVES)) u_lives (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr_cnt),
        .i_inc   (1'b0),
        .i_dec   (w_lives_dec),
        .o_count (lives)
    );

    assign catch_pulse = r_catch;
    assign miss_pulse  = r_miss;
    assign respawn     = r_respawn;
    assign push_clr    = r_push_clr;
    assign game_over   = r_game_over;
    assign win         = r_win;

endmodule : catch_judge
`default_nettype wire

// File: tb/tb_catch_judge.sv
`default_nettype none
// ============================================================================
// Module      : tb_catch_judge
// Description : Directed self-checking bench for catch_judge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_catch_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fall_tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic [9:0]  fall_x = '0, fall_y = '0, stack_x = '0, height = '0;
    logic [1:0]  fall_clr = '0;
    logic        catch_pulse, miss_pulse, respawn, game_over, win;
    logic [1:0]  push_clr, lives;
    logic [13:0] score;

    int checks = 0;
    int failures = 0;

    catch_judge dut (
        .clk         (clk),
        .rst         (rst),
        .fall_tick   (fall_tick),
        .start       (start),
        .pause       (pause),
        .fall_x      (fall_x),
        .fall_y      (fall_y),
        .fall_clr    (fall_clr),
        .stack_x     (stack_x),
        .height      (height),
        .catch_pulse (catch_pulse),
        .push_clr    (push_clr),
        .miss_pulse  (miss_pulse),
        .respawn     (respawn),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Tick in cycle k; returns positioned in cycle k+2
    task automatic tick_at(input logic [9:0] x, input logic [9:0] y, input logic [1:0] c);
        fall_x = x; fall_y = y; fall_clr = c;
        fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        step();
    endtask

    // Tick with the item back at the top, releasing COOLDOWN
    task automatic to_play();
        fall_y = 10'd0;
        fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
    endtask

    task automatic check_pulses(input string tag, input logic c, input logic m, input logic r);
        check({tag, "_catch"}, 32'(catch_pulse), 32'(c));
        check({tag, "_miss"},  32'(miss_pulse),  32'(m));
        check({tag, "_resp"},  32'(respawn),     32'(r));
    endtask

    initial begin
        stack_x = 10'd300;
        // Reset state
        #2;
        check_pulses("rst", 0, 0, 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), 0);
        check("rst_over",  32'(game_over), 0);
        check("rst_pclr",  32'(push_clr), 0);
        step();
        rst = 1'b1;
        step();

        // Ticks before start are ignored
        tick_at(10'd320, 10'd440, 2'd1);
        check_pulses("idle", 0, 0, 0);

        // Start initialises counters next cycle
        do_start();
        check("start_score", 32'(score), 0);
        check("start_lives", 32'(lives), 3);

        // Catch: item 320..360 over stack 300..380
        fall_x = 10'd320; fall_y = 10'd440; fall_clr = 2'd2; fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        check("catch_k1", 32'(catch_pulse), 0);
        step();
        check_pulses("catch", 1, 0, 1);
        check("catch_pclr",  32'(push_clr), 2);
        check("catch_score", 32'(score), 1);
        check("catch_lives", 32'(lives), 3);
        step();
        check_pulses("catch_end", 0, 0, 0);

        // Item held at the landing line through COOLDOWN: no second judgment
        tick_at(10'd320, 10'd440, 2'd2);
        check_pulses("cool", 0, 0, 0);
        check("cool_score", 32'(score), 1);
        to_play();

        // Paused landing tick is ignored
        pause = 1'b1;
        tick_at(10'd320, 10'd440, 2'd2);
        check_pulses("pause", 0, 0, 0);
        pause = 1'b0;

        // Edge contact is a miss; one pixel further right is a catch
        tick_at(10'd260, 10'd440, 2'd0);
        check_pulses("edge260", 0, 1, 1);
        check("edge260_lives", 32'(lives), 2);
        to_play();
        tick_at(10'd261, 10'd440, 2'd3);
        check_pulses("edge261", 1, 0, 1);
        check("edge261_pclr",  32'(push_clr), 3);
        check("edge261_score", 32'(score), 2);
        to_play();

        // Two more misses exhaust lives and lose
        tick_at(10'd0, 10'd440, 2'd0);
        check("miss2_lives", 32'(lives), 1);
        check("miss2_over",  32'(game_over), 0);
        to_play();
        tick_at(10'd0, 10'd440, 2'd0);
        check_pulses("lose", 0, 1, 1);
        check("lose_lives", 32'(lives), 0);
        check("lose_over",  32'(game_over), 1);
        check("lose_win",   32'(win), 0);
        tick_at(10'd0, 10'd440, 2'd0);
        check_pulses("over_tick", 0, 0, 0);
        check("over_lives", 32'(lives), 0);

        // Start coinciding with a tick in OVER restarts without judging
        fall_tick = 1'b1;
        do_start();
        fall_tick = 1'b0;
        check("restart_score", 32'(score), 0);
        check("restart_lives", 32'(lives), 3);
        check("restart_over",  32'(game_over), 0);
        step();
        check_pulses("restart", 0, 0, 0);

        // Catch with height 19 wins (land line at 80)
        height = 10'd19;
        tick_at(10'd320, 10'd60, 2'd1);
        check_pulses("win", 1, 0, 1);
        check("win_over",  32'(game_over), 1);
        check("win_win",   32'(win), 1);
        check("win_score", 32'(score), 1);
        height = 10'd0;

        // Reset while in JUDGE clears outputs asynchronously
        do_start();
        fall_x = 10'd320; fall_y = 10'd440; fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_pulses("rstj", 0, 0, 0);
        check("rstj_lives", 32'(lives), 0);
        check("rstj_over",  32'(game_over), 0);
        step();
        rst = 1'b1;
        tick_at(10'd320, 10'd440, 2'd1);
        check_pulses("rstj_idle", 0, 0, 0);

        // Score saturation: 9999 catches, then one more
        do_start();
        for (int i = 0; i < 9999; i++) begin
            tick_at(10'd320, 10'd440, 2'd1);
            to_play();
        end
        check("sat_pre", 32'(score), 9999);
        tick_at(10'd320, 10'd440, 2'd1);
        check("sat_catch", 32'(catch_pulse), 1);
        check("sat_score", 32'(score), 9999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_catch_judge
`default_nettype wire

// File: doc/catch_judge.md
# catch_judge

Game-rule stage downstream of `falling_item` and `stack`, running on the `clk` domain. On each fall tick it compares the falling item against the top of the stack and decides whether the item was caught or missed. It emits one-cycle catch, miss and respawn pulses, maintains score, lives and game-over state, and feeds `stack` (push), `falling_item` (respawn) and the score display.

## Interface
- `BLOCK_W`, 40: falling item width, px
- `BLOCK_H`, 20: item and stack-layer height, px
- `STACK_W`, 80: stack top width, px
- `FLOOR_Y`, 460: y of the stack base, px
- `MAX_HEIGHT`, 20: number of layers that wins the game
- `LIVES`, 3: misses allowed (1..3)

- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset (asserted at 0)
- `fall_tick` in 1: one-cycle pulse per `fall_clk` step, already synchronised to `clk`
- `start` in 1: one-cycle start pulse, debounced upstream
- `pause` in 1: level; while high, ticks are ignored
- `fall_x`, `fall_y` in 10 each: item top-left corner
- `fall_clr` in 2: item colour
- `stack_x` in 10: stack top left edge
- `height` in 10: current layer count
- `catch_pulse` out 1: item caught
- `push_clr` out 2: colour to push; valid only with `catch_pulse`
- `miss_pulse` out 1: item missed
- `respawn` out 1: request `falling_item` to restart at the top
- `score` out 14: caught count, saturates at 9999
- `lives` out 2: remaining lives
- `game_over` out 1: level
- `win` out 1: level; qualifies `game_over`

## Operation
- States: `IDLE`, `PLAY`, `JUDGE`, `COOLDOWN`, `OVER`.
- Reset values: state `IDLE`; `score` 0; `lives` 0; all pulses, `push_clr`, `game_over` and `win` are 0.
- `IDLE` or `OVER`, on `start`: go to `PLAY`; `score` is set to 0, `lives` to `LIVES`, `game_over` and `win` to 0.
- `PLAY`, on `fall_tick` with `pause` low:
  - Compute `land` = `FLOOR_Y` − `height`·`BLOCK_H`, clamped to 0.
  - If `fall_y` + `BLOCK_H` ≥ `land`, capture `fall_x` and `fall_clr` and go to `JUDGE`.
- `JUDGE` lasts one cycle and is evaluated regardless of `pause`. The overlap test is `fall_x` + `BLOCK_W` > `stack_x` AND `fall_x` < `stack_x` + `STACK_W`, using the captured `fall_x`.
  - **Catch:** `catch_pulse` and `respawn` high; `push_clr` = captured colour; `score` +1 (saturating).
    - If `height` + 1 ≥ `MAX_HEIGHT`: go to `OVER` with `win` = 1.
    - Otherwise go to `COOLDOWN`.
  - **Miss:** `miss_pulse` and `respawn` high; `lives` −1.
    - If `lives` was 1: go to `OVER` with `win` = 0.
    - Otherwise go to `COOLDOWN`.
- `COOLDOWN`: on `fall_tick` with `pause` low, if `fall_y` + `BLOCK_H` < `land`, go to `PLAY`. This prevents judging the same item twice.
- `OVER`: `game_over` = 1. `respawn` is still pulsed on the final judgment.
- Arithmetic:
  - All geometry is computed in 11-bit unsigned, so nothing wraps.
  - `height`·`BLOCK_H` is computed in 16 bits before the clamp.
  - `score` at 9999 stays at 9999.
  - `lives` never underflows below 0.
- Boundaries:
  - `start` in `PLAY`, `JUDGE` or `COOLDOWN` is ignored.
  - A `start` that coincides with a tick in `OVER` takes the start; that tick is not evaluated.
  - Edge contact (`fall_x` + `BLOCK_W` == `stack_x`) is a miss.
  - Reset mid-game forces the reset values asynchronously.

## Timing
- `fall_tick` in cycle k with landing true: `JUDGE` in cycle k+1.
- `catch_pulse`/`miss_pulse`/`respawn`/`push_clr` are registered and high only in cycle k+2. `score`, `lives`, `game_over` and `win` update in the same cycle k+2.
- Each pulse is exactly one cycle; `catch_pulse` and `miss_pulse` are never high together.
- `start` in cycle j: state is `PLAY` and `score`/`lives` are initialised in cycle j+1.
- `fall_tick` is ignored in `JUDGE`.

## Structure
- Shared package `sky_pkg`:
  - state enum;
  - geometry defaults (`BLOCK_W`, `BLOCK_H`, `STACK_W`, `FLOOR_Y`);
  - `SCORE_MAX` = 9999.
  - `stack` and `draw` use the same package.
- One sub-module, `sat_counter`: parameterised width and max, with sync clear, increment, decrement and saturation at both ends. It is instantiated twice, for `score` and for `lives`.

## Test plan
- **Catch:** `start`; `height` = 0, `stack_x` = 300, item at `fall_x` = 320 reaching `fall_y` = 440 with tick in cycle k → `catch_pulse` and `respawn` in k+2, `push_clr` = `fall_clr`, `score` = 1, `lives` = 3.
- **Miss and lose:** three misses with `fall_x` = 0, `stack_x` = 300 → `lives` 2, 1, 0; `game_over` = 1, `win` = 0 in the third k+2; further ticks produce no pulses.
- **Edge contact:** `fall_x` = 260, `stack_x` = 300 (right edge touches) → miss. `fall_x` = 261 → catch.
- **Win and saturation:** `height` = 19 and catch → `game_over` = 1, `win` = 1. With `score` preloaded to 9999 via catches, a further catch keeps 9999.
- **Pause and no double judgment:** `pause` high during a landing tick → no `JUDGE`. Hold `fall_y` at the landing line through `COOLDOWN` → exactly one pulse.
- **Reset and restart:** `rst` low in `JUDGE` → all outputs 0 immediately, state `IDLE`. `start` in `OVER` → `score` 0, `lives` 3 the next cycle.
